prescaler_sched: RTL

// - Shared tick scheduler driven by the 16 MHz system clock; one free-running counter serves CHANNELS consumers.
// - Each channel gets a 1-cycle clock-enable strobe every 2^sel cycles; sel and enable are runtime-configurable.
// - Reconfiguration uses a valid/ready port, with changes applied only at the channel's period boundary (glitch-free).
// - Sits between the USB CDC control logic and the demo timing blocks (UART bit ticks, LED blink, timeouts).

---
 rtl/prescaler_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/prescaler_sched.sv
// prescaler_sched: shared tick scheduler. One free-running counter feeds
// CHANNELS strobe channels. Each channel produces a 1-cycle strobe every
// 2^sel cycles. Config updates go through a single shadow slot and are
// applied only at the target channel's period boundary, so no strobe is
// ever shortened or glitched.
// Optional feature: define PRESCALER_SCHED_CLKOUT_EN to build the per-channel
// 50% duty square-wave outputs on clk_o; otherwise clk_o is tied to 0.
module prescaler_sched #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int SEL_W    = 4
) (
  input  logic                clk_16mhz_i,
  input  logic                rstn_i,
  input  logic                sync_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [2:0]          cfg_ch_i,
  input  logic [SEL_W-1:0]    cfg_sel_i,
  input  logic                cfg_en_i,
  output logic [CHANNELS-1:0] strobe_o,
  output logic [CHANNELS-1:0] clk_o,
  output logic                err_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [3:0]       CH_LIM  = 4'(CHANNELS);
  localparam logic [SEL_W:0]   SEL_MAX = (SEL_W + 1)'(CNT_W);

  logic [0:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [CHANNELS-1:0] en_r;
  logic [SEL_W-1:0]    sel_r [CHANNELS];

  logic [2:0]          sh_ch;
  logic [SEL_W-1:0]    sh_sel;
  logic                sh_en;
  logic                sh_force;

  logic [CHANNELS-1:0] hit;
  logic                target_ok;
  logic                handshake;
  logic                req_bad;
  logic                apply;

  // Low-bit mask for a period of 2^s cycles (s = CNT_W gives all ones).
  function automatic logic [CNT_W-1:0] sel_mask(input logic [SEL_W-1:0] s);
    logic [CNT_W:0] ext;
    ext = ({{CNT_W{1'b0}}, 1'b1} << s) - (CNT_W + 1)'(1);
    return ext[CNT_W-1:0];
  endfunction

  assign cfg_ready_o = (state == ST_IDLE);
  assign handshake   = cfg_valid_i && cfg_ready_o;
  assign req_bad     = ({1'b0, cfg_ch_i} >= CH_LIM) || ({1'b0, cfg_sel_i} > SEL_MAX);

  // Per-channel boundary detect and the apply decision for the pending slot.
  always_comb begin
    hit       = '0;
    target_ok = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = en_r[c] && ((cnt & sel_mask(sel_r[c])) == sel_mask(sel_r[c]));
      if (sh_ch == 3'(c)) begin
        target_ok = !en_r[c] || hit[c];
      end
    end
    apply = (state == ST_PENDING) && (sh_force || sync_i || target_ok);
  end

  // Shared free-running counter; sync restarts it for phase alignment.
  always_ff @(posedge clk_16mhz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (sync_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered strobes, always computed from the config in force this cycle.
  always_ff @(posedge clk_16mhz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      strobe_o <= '0;
    end else if (sync_i) begin
      strobe_o <= '0;
    end else begin
      strobe_o <= hit;
    end
  end

  // Config FSM: accept into the shadow slot, hold until the target boundary.
  always_ff @(posedge clk_16mhz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      sh_ch    <= '0;
      sh_sel   <= '0;
      sh_en    <= 1'b0;
      sh_force <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      err_o <= handshake && req_bad;
      if (handshake && !req_bad) begin
        state    <= ST_PENDING;
        sh_ch    <= cfg_ch_i;
        sh_sel   <= cfg_sel_i;
        sh_en    <= cfg_en_i;
        sh_force <= sync_i;
      end else if (apply) begin
        state    <= ST_IDLE;
        sh_force <= 1'b0;
      end
    end
  end

  // Live channel configuration, updated only on the apply edge.
  always_ff @(posedge clk_16mhz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_r <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sel_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (apply && (sh_ch == 3'(c))) begin
          en_r[c]  <= sh_en;
          sel_r[c] <= sh_sel;
        end
      end
    end
  end

`ifdef PRESCALER_SCHED_CLKOUT_EN
  logic [CHANNELS-1:0] clk_next;

  // Square wave per channel: counter bit sel-1 gives 50% duty at period 2^sel.
  always_comb begin
    logic [CNT_W-1:0] shv;
    shv      = '0;
    clk_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      shv = cnt >> (sel_r[c] - SEL_W'(1));
      clk_next[c] = en_r[c] && (sel_r[c] != '0) && shv[0];
    end
  end

  // Register the square waves so clk_o is glitch-free.
  always_ff @(posedge clk_16mhz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clk_o <= '0;
    end else begin
      clk_o <= clk_next;
    end
  end
`else
  assign clk_o = '0;
`endif

endmodule
